// File: rtl/fifo_wr_arbiter_if.sv
// Bus bundle between the requesters, the write arbiter and the FIFO write port.
// The arbiter connects through the slave modport; the requester/FIFO side uses master.
interface fifo_wr_arbiter_if #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned WIDTH = 8,
    parameter int unsigned IDW   = 2
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       req_ready;
    logic                  fifo_full;
    logic                  fifo_half;
    logic                  fifo_overflow;
    logic                  fifo_wr_enb;
    logic [WIDTH-1:0]      fifo_wr_data;
    logic [IDW-1:0]        grant_id;
    logic                  busy;
    logic                  err_sticky;
    logic                  err_clr;

    modport master (
        output req_valid, req_data, fifo_full, fifo_half, fifo_overflow, err_clr,
        input  req_ready, fifo_wr_enb, fifo_wr_data, grant_id, busy, err_sticky
    );

    modport slave (
        input  req_valid, req_data, fifo_full, fifo_half, fifo_overflow, err_clr,
        output req_ready, fifo_wr_enb, fifo_wr_data, grant_id, busy, err_sticky
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port among NREQ requesters.
// Optional macro FIFO_WR_ARB_HALF_THROTTLE_EN: favour requester 0 while the FIFO is half full.
module fifo_wr_arbiter #(
    parameter int unsigned NREQ      = 4,
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned MAX_BURST = 4,
    parameter int unsigned IDW       = 2
) (
    input  logic           clk,
    input  logic           rstn,
    fifo_wr_arbiter_if.slave io_bus
);

    typedef enum logic [0:0] {StIdle, StBurst} state_e;

    state_e         r_state;
    logic [IDW-1:0] r_rr_ptr;
    logic [IDW-1:0] r_grant_id;
    logic [3:0]     r_beat_cnt;
    logic           r_err_sticky;

    logic [NREQ-1:0] w_elig;
    logic [IDW:0]    w_idx;
    logic            w_any;
    logic [IDW-1:0]  w_pick;
    logic            w_gnt_valid;
    logic            w_xfer;
    logic            w_last_beat;
    logic            w_throttle;
    logic [IDW:0]    w_ptr_inc;
    logic [IDW-1:0]  w_next_ptr;

    // Eligible set, then first eligible index scanning upward from r_rr_ptr with wrap.
    always_comb begin
        w_elig = io_bus.req_valid;
`ifdef FIFO_WR_ARB_HALF_THROTTLE_EN
        if (io_bus.fifo_half) begin
            w_elig = {{(NREQ-1){1'b0}}, io_bus.req_valid[0]};
        end
`endif
        w_any  = 1'b0;
        w_pick = '0;
        w_idx  = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = {1'b0, r_rr_ptr} + (IDW+1)'(k);
            if (w_idx >= (IDW+1)'(NREQ)) begin
                w_idx = w_idx - (IDW+1)'(NREQ);
            end
            if (!w_any && w_elig[w_idx[IDW-1:0]]) begin
                w_any  = 1'b1;
                w_pick = w_idx[IDW-1:0];
            end
        end
    end

    always_comb begin
        w_gnt_valid = io_bus.req_valid[r_grant_id];
        w_xfer      = (r_state == StBurst) && w_gnt_valid && !io_bus.fifo_full;
        w_last_beat = (r_beat_cnt == 4'(MAX_BURST - 1));
        w_ptr_inc   = {1'b0, r_grant_id} + 1'b1;
        w_next_ptr  = (w_ptr_inc >= (IDW+1)'(NREQ)) ? '0 : w_ptr_inc[IDW-1:0];
    end

`ifdef FIFO_WR_ARB_HALF_THROTTLE_EN
    assign w_throttle = io_bus.fifo_half && (r_grant_id != '0);
`else
    logic w_unused_half;
    assign w_unused_half = io_bus.fifo_half;
    assign w_throttle    = 1'b0;
`endif

    // Write port is combinational so the FIFO captures data on the handshake edge.
    always_comb begin
        io_bus.req_ready    = '0;
        io_bus.fifo_wr_enb  = 1'b0;
        io_bus.fifo_wr_data = '0;
        if (r_state == StBurst) begin
            io_bus.req_ready[r_grant_id] = !io_bus.fifo_full;
            io_bus.fifo_wr_enb           = w_xfer;
            if (w_xfer) begin
                io_bus.fifo_wr_data = io_bus.req_data[r_grant_id*WIDTH +: WIDTH];
            end
        end
        io_bus.busy       = (r_state == StBurst);
        io_bus.grant_id   = r_grant_id;
        io_bus.err_sticky = r_err_sticky;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state      <= StIdle;
            r_rr_ptr     <= '0;
            r_grant_id   <= '0;
            r_beat_cnt   <= '0;
            r_err_sticky <= 1'b0;
        end else begin
            // A set event beats a simultaneous clear.
            if (w_xfer && io_bus.fifo_overflow) begin
                r_err_sticky <= 1'b1;
            end else if (io_bus.err_clr) begin
                r_err_sticky <= 1'b0;
            end

            unique case (r_state)
                StIdle: begin
                    if (w_any) begin
                        r_grant_id <= w_pick;
                        r_beat_cnt <= '0;
                        r_state    <= StBurst;
                    end
                end
                StBurst: begin
                    if (!w_gnt_valid) begin
                        r_state  <= StIdle;
                        r_rr_ptr <= w_next_ptr;
                    end else if (w_xfer) begin
                        r_beat_cnt <= r_beat_cnt + 4'd1;
                        if (w_last_beat || w_throttle) begin
                            r_state  <= StIdle;
                            r_rr_ptr <= w_next_ptr;
                        end
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: expected writes are queued as stimulus is driven
// and popped when the write port fires; state checks follow the cycle-level schedule.
module tb_fifo_wr_arbiter;

    localparam int NREQ = 4;
    localparam int WIDTH = 8;
    localparam int IDW = 2;

    typedef struct {
        int         id;
        logic [7:0] data;
    } exp_t;

    logic clk;
    logic rstn;
    int   n_total = 0;
    int   n_bad   = 0;
    int   wr_cnt  = 0;
    int   seq     [NREQ];
    int   exp_seq [NREQ];
    exp_t sb[$];

    fifo_wr_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) bus ();

    fifo_wr_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .MAX_BURST(4), .IDW(IDW)) dut (
        .clk    (clk),
        .rstn   (rstn),
        .io_bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [7:0] data_of(input int i, input int s);
        return {3'(i), 5'(s)};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push(input int id, input int n);
        for (int j = 0; j < n; j++) begin
            sb.push_back('{id: id, data: data_of(id, exp_seq[id])});
            exp_seq[id]++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, 32'(bus.req_ready), 0);
        check({tag, "_wenb"}, 32'(bus.fifo_wr_enb), 0);
        check({tag, "_wdata"}, 32'(bus.fifo_wr_data), 0);
        check({tag, "_gid"}, 32'(bus.grant_id), 0);
        check({tag, "_busy"}, 32'(bus.busy), 0);
        check({tag, "_err"}, 32'(bus.err_sticky), 0);
    endtask

    // Requester data source: each accepted beat advances that requester's sequence number.
    initial begin
        logic [NREQ-1:0] hs;
        for (int i = 0; i < NREQ; i++) begin
            seq[i] = 0;
            bus.req_data[i*WIDTH +: WIDTH] = data_of(i, 0);
        end
        forever begin
            @(negedge clk);
            hs = bus.req_valid & bus.req_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < NREQ; i++) begin
                if (hs[i]) seq[i]++;
                bus.req_data[i*WIDTH +: WIDTH] = data_of(i, seq[i]);
            end
        end
    end

    // Write-port monitor, sampled on the falling edge ahead of the capturing rising edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.fifo_wr_enb) begin
                wr_cnt++;
                check("sb_has_entry", 32'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("wr_data", 32'(bus.fifo_wr_data), 32'(e.data));
                    check("wr_gid", 32'(bus.grant_id), 32'(e.id));
                    check("wr_ready", 32'(bus.req_ready), 32'(1 << e.id));
                end
            end else begin
                check("idle_wdata", 32'(bus.fifo_wr_data), 0);
            end
        end
    end

    initial begin
        for (int i = 0; i < NREQ; i++) exp_seq[i] = 0;
        rstn              = 1'b0;
        bus.req_valid     = '0;
        bus.fifo_full     = 1'b0;
        bus.fifo_half     = 1'b0;
        bus.fifo_overflow = 1'b0;
        bus.err_clr       = 1'b0;

        repeat (3) tick();
        check_reset_outputs("rst");
        rstn = 1'b1;
        tick();
        check("rst_idle_busy", 32'(bus.busy), 0);

        // All requesters valid: grants 0,1,2,3,0 with a bubble after every 4-beat burst.
        bus.req_valid = 4'hF;
        push(0, 4); push(1, 4); push(2, 4); push(3, 4); push(0, 1);
        for (int k = 1; k <= 22; k++) begin
            tick();
            check($sformatf("rr_busy_%0d", k), 32'(bus.busy), 32'(k % 5 != 0));
            check($sformatf("rr_gid_%0d", k), 32'(bus.grant_id), 32'(((k - 1) / 5) % 4));
            if (k == 20) check("rr_16_writes", 32'(wr_cnt), 16);
        end
        bus.req_valid = '0;
        tick();
        check("rr_drop_busy", 32'(bus.busy), 0);
        check("rr_sb_empty", 32'(sb.size()), 0);

        // Requester 2 alone for two beats, then drops valid.
        bus.req_valid = 4'b0100;
        push(2, 2);
        tick();
        check("r2_gid", 32'(bus.grant_id), 2);
        check("r2_busy", 32'(bus.busy), 1);
        tick(); tick();
        bus.req_valid = '0;
        tick();
        check("r2_end_busy", 32'(bus.busy), 0);
        check("r2_hold_gid", 32'(bus.grant_id), 2);
        check("r2_writes", 32'(wr_cnt), 19);
        bus.req_valid = 4'hF;
        tick();
        check("r2_next_gid", 32'(bus.grant_id), 3);
        bus.req_valid = 4'b1000;
        push(3, 4);

        // FIFO full for five cycles after beat 2 of requester 3.
        tick(); tick();
        bus.fifo_full = 1'b1;
        #1;
        check("full_ready0", 32'(bus.req_ready), 0);
        check("full_wenb0", 32'(bus.fifo_wr_enb), 0);
        for (int k = 0; k < 5; k++) begin
            tick();
            check($sformatf("full_ready_%0d", k), 32'(bus.req_ready), 0);
            check($sformatf("full_wenb_%0d", k), 32'(bus.fifo_wr_enb), 0);
            check($sformatf("full_gid_%0d", k), 32'(bus.grant_id), 3);
            check($sformatf("full_busy_%0d", k), 32'(bus.busy), 1);
        end
        bus.fifo_full = 1'b0;
        tick(); tick();
        check("full_done_busy", 32'(bus.busy), 0);
        check("full_sb_empty", 32'(sb.size()), 0);
        check("full_no_err", 32'(bus.err_sticky), 0);
        bus.req_valid = '0;
        tick();

        // Sticky error set, clear, and set-wins-over-clear.
        bus.req_valid = 4'b0001;
        push(0, 4);
        tick();
        bus.fifo_overflow = 1'b1;
        tick();
        bus.fifo_overflow = 1'b0;
        check("err_set", 32'(bus.err_sticky), 1);
        tick();
        check("err_hold", 32'(bus.err_sticky), 1);
        bus.err_clr = 1'b1;
        tick();
        check("err_cleared", 32'(bus.err_sticky), 0);
        bus.fifo_overflow = 1'b1;
        tick();
        check("err_set_wins", 32'(bus.err_sticky), 1);
        check("err_burst_end", 32'(bus.busy), 0);
        bus.err_clr       = 1'b0;
        bus.fifo_overflow = 1'b0;
        bus.req_valid     = '0;
        tick();
        check("err_stays", 32'(bus.err_sticky), 1);

        // Asynchronous reset after beat 1 of a requester 2 burst.
        bus.req_valid = 4'b0101;
        push(2, 1);
        tick();
        check("ar_gid", 32'(bus.grant_id), 2);
        tick();
        #2;
        rstn = 1'b0;
        #1;
        check_reset_outputs("arst");
        tick();
        rstn = 1'b1;
        push(0, 4);
        tick();
        check("ar_first_gid", 32'(bus.grant_id), 0);
        check("ar_first_busy", 32'(bus.busy), 1);
        repeat (4) tick();
        check("ar_end_busy", 32'(bus.busy), 0);
        bus.req_valid = '0;
        tick();
        check("ar_sb_empty", 32'(sb.size()), 0);

        // fifo_half with requesters 1 and 0: throttled or ignored depending on the build.
        bus.req_valid = 4'b0010;
`ifdef FIFO_WR_ARB_HALF_THROTTLE_EN
        push(1, 2); push(0, 4);
        tick();
        check("th_gid1", 32'(bus.grant_id), 1);
        tick();
        bus.fifo_half = 1'b1;
        bus.req_valid = 4'b0011;
        tick();
        check("th_cut_busy", 32'(bus.busy), 0);
        tick();
        check("th_gid0", 32'(bus.grant_id), 0);
        repeat (4) tick();
`else
        bus.fifo_half = 1'b1;
        push(1, 4); push(0, 4);
        tick();
        check("th_gid1", 32'(bus.grant_id), 1);
        tick();
        bus.req_valid = 4'b0011;
        repeat (3) tick();
        check("th_full_burst_end", 32'(bus.busy), 0);
        tick();
        check("th_gid0", 32'(bus.grant_id), 0);
        repeat (4) tick();
`endif
        check("th_end_busy", 32'(bus.busy), 0);
        bus.req_valid = '0;
        bus.fifo_half = 1'b0;
        tick();
        check("th_sb_empty", 32'(sb.size()), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin, burst-based write arbiter that shares one synchronous FIFO write port among NREQ requesters.
- Sits directly in front of the FIFO and drives its wr_enb and wr_data.
- Uses the FIFO's full, half and overflow flags for backpressure and error reporting.
- Each requester uses a valid/ready handshake; a grant is held for up to MAX_BURST beats, then rotates.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 8, data width; must equal the FIFO data width.
- MAX_BURST, 4, maximum beats per grant (1..15).
- IDW, 2, grant index width; must be at least clog2(NREQ).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rstn  in  1  reset, asynchronous, active-low.
- req_valid  in  NREQ  per-requester data valid.
- req_data  in  NREQ*WIDTH  packed data; requester i occupies bits [i*WIDTH +: WIDTH].
- req_ready  out  NREQ  per-requester accept; at most one bit high.
- fifo_full  in  1  FIFO full flag.
- fifo_half  in  1  FIFO half flag.
- fifo_overflow  in  1  FIFO overflow flag.
- fifo_wr_enb  out  1  FIFO write enable.
- fifo_wr_data  out  WIDTH  FIFO write data.
- grant_id  out  IDW  index of the current grant owner.
- busy  out  1  high in the BURST state.
- err_sticky  out  1  set by fifo_overflow while a write is issued; held until err_clr.
- err_clr  in  1  synchronous clear of err_sticky.

Behaviour:
- Reset (asynchronous, rstn low):
  - state = IDLE; rr_ptr = 0; grant_id = 0; beat_cnt = 0; err_sticky = 0.
  - req_ready = 0, fifo_wr_enb = 0, fifo_wr_data = 0, busy = 0.
  - Asserting rstn mid-burst aborts the burst at once; a beat in flight is not written.
- State machine, IDLE:
  - If any req_valid is high, pick the first valid index scanning from rr_ptr upward, wrapping at NREQ.
  - Register that index into grant_id, clear beat_cnt, go to BURST.
  - No transfer happens in IDLE, so there is 1 cycle of arbitration latency.
- State machine, BURST:
  - req_ready[grant_id] = !fifo_full; all other ready bits are 0.
  - A beat transfers on a clock edge where req_valid[g] and req_ready[g] are both high; beat_cnt then increments.
  - The burst ends, with next state IDLE and rr_ptr = grant_id+1 mod NREQ, when either:
    - a beat transfers and beat_cnt reaches MAX_BURST, or
    - req_valid[g] is low in any BURST cycle.
  - The grant is always released through IDLE, so there is a 1-cycle bubble between grants.
- Write port (combinational in BURST):
  - fifo_wr_enb = req_valid[g] & !fifo_full.
  - fifo_wr_data = req_data slice g when fifo_wr_enb is high, else 0.
  - Zero added latency; the FIFO captures data on the same edge as the handshake.
- Full: while fifo_full is high, the arbiter stalls and holds the grant with no timeout. beat_cnt does not advance and fifo_wr_enb is never asserted, so overflow is impossible by construction.
- Error: err_sticky is set when fifo_wr_enb and fifo_overflow are both high. If err_clr and a set event occur in the same cycle, the set wins.
- Fairness: any requester that keeps its valid high is granted within (NREQ-1)*(MAX_BURST+1) cycles plus full-stall cycles.
- grant_id holds its last value while in IDLE.

Optional Feature:
- Macro: FIFO_WR_ARB_HALF_THROTTLE_EN.
- Defined:
  - In IDLE with fifo_half high, only requester 0 is eligible; others wait, and rr_ptr is unchanged if requester 0 is not valid.
  - In BURST with fifo_half high and grant_id != 0, the burst ends after the current transfer regardless of beat_cnt.
- Undefined: fifo_half is ignored and arbitration is plain round-robin.

Test Plan:
- Reset, then all four requesters valid continuously, FIFO drained by the bench.
  - Required: grant order 0,1,2,3,0.
  - Required: 4 beats per grant, 1 idle cycle between grants, 16 writes in 20 cycles.
- Requester 2 alone, valid for 2 beats then drops valid.
  - Required: 2 writes, then IDLE.
  - Required: rr_ptr = 3, so the next grant with all valid goes to requester 3.
- FIFO full asserted for 5 cycles mid-burst after beat 2.
  - Required: fifo_wr_enb = 0 and req_ready = 0 for those 5 cycles, grant held.
  - Required: beats 3 and 4 complete after full drops; no overflow.
- Force fifo_overflow high together with fifo_wr_enb.
  - Required: err_sticky = 1 next cycle and stays set.
  - Required: err_clr clears it; err_clr together with a new overflow leaves err_sticky = 1.
- rstn low mid-burst at beat 1.
  - Required: all outputs return to reset values asynchronously.
  - Required: after release, the first grant goes to the lowest valid index.
- Throttle check with the macro defined, fifo_half high, requesters 1 and 0 valid.
  - Required: requester 0 is granted first.
  - Required: a requester 1 burst started before half rose ends after its current beat.
